mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the fetch stage (instruction reads) and the memory stage (data reads/writes).
- Sits between the pipeline and memory.
- Exports per-requester stall signals that the hazard unit ORs into stallF and the memory-stage stall.
- Data requests win by default; a starvation counter guarantees fetch forward progress.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_MAX, 4, consecutive data grants tolerated while fetch is pending before fetch is forced; range 1..15

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch read request; held with i_addr stable until i_ack
- i_addr  in  ADDR_W  fetch address
- i_ack  out  1  one-cycle pulse: fetch transaction complete, i_rdata valid
- i_rdata  out  DATA_W  registered fetch read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle pulse: data transaction complete
- d_rdata  out  DATA_W  registered data read value
- stall_i  out  1  i_req & ~i_ack (combinational)
- stall_d  out  1  d_req & ~d_ack (combinational)
- mem_req  out  1  registered request to backing memory
- mem_we  out  1  registered write enable
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_ack  in  1  memory completion pulse; any latency of 1 cycle or more
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- Reset (async): state=IDLE. All outputs 0, including i_rdata, d_rdata, mem_addr and mem_wdata. starve_cnt=0.

IDLE arbitration:
- Only d_req: grant data.
- Only i_req: grant fetch.
- Both asserted: data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
- On grant, next state is BUSY_x. mem_req/mem_we/mem_addr/mem_wdata are registered from the winner at the same edge; mem_we=0 for fetch.

BUSY_x:
- Hold mem_* constant until mem_ack=1.
- On mem_ack: mem_req drops at the next edge.
- For reads, capture mem_rdata into i_rdata/d_rdata; a data write leaves d_rdata unchanged.
- Move to RESP_x.

RESP_x:
- Assert i_ack or d_ack for exactly this one cycle.
- Next state is always IDLE; no back-to-back grant. The requester therefore drops or renews req before the next arbitration and is never double-served.

Latency and throughput:
- Minimum req-to-ack latency is 3 cycles (grant edge, mem_ack in the first BUSY cycle, RESP).
- Throughput is at most 1 transaction per 3 cycles plus memory latency.

Starvation counter (updated at the grant edge):
- Data grant while i_req=1: starve_cnt+1, saturating at STARVE_MAX.
- Fetch grant: starve_cnt cleared.
- Data grant while i_req=0: starve_cnt cleared.

Boundary conditions:
- mem_ack in IDLE or RESP_x (stray, or late after reset) is ignored; no state change.
- A requester dropping req mid-transaction is a protocol violation. The transaction completes anyway and ack still pulses.
- New reqs arriving in BUSY/RESP wait; stall stays high meanwhile.
- Reset mid-transaction: immediate return to IDLE with mem_req=0; the in-flight result is discarded.
- stall_x is 0 whenever req_x=0.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum encoding (3 bits)
  - the localparams for the 4-bit starve counter width
- Sub-module arb_starve_counter: saturating counter with inputs clr, inc, sat_val and outputs cnt, at_max.
- Everything else stays in mem_port_arbiter.

Test Plan:
- Single fetch: i_req=1, i_addr=0x40, mem_ack 2 cycles after mem_req with mem_rdata=0x20080005 -> i_ack pulses once on cycle 4 with i_rdata=0x20080005; stall_i=1 on cycles 0-3, then 0.
- Simultaneous: i_req=d_req=1 (d_addr=0x100, d_we=1, d_wdata=0xDEADBEEF), 1-cycle memory -> data served first with mem_we=1, mem_wdata=0xDEADBEEF; fetch granted in the next IDLE; d_rdata stays 0.
- Starvation: i_req held, d_req renewed continuously, STARVE_MAX=4 -> exactly 4 data grants, then a fetch grant, then starve_cnt=0.
- Stray mem_ack: pulse mem_ack in IDLE with no reqs -> no ack, state stays IDLE, outputs unchanged.
- Reset mid-op: assert rst during BUSY_D for a read at 0x200, then deassert; reissue the request -> mem_req=0 immediately on rst, no d_ack from the aborted transaction, reissued read completes normally.
- Long latency: mem_ack after 10 cycles -> mem_addr/mem_we stable throughout, exactly one ack pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_I = 3'd1,
        ST_BUSY_D = 3'd2,
        ST_RESP_I = 3'd3,
        ST_RESP_D = 3'd4
    } arb_state_t;

    localparam int STARVE_W = 4;
    localparam logic [STARVE_W-1:0] STARVE_ZERO = '0;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants taken while fetch was waiting.
module arb_starve_counter
    import mem_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                inc,
    input  logic [STARVE_W-1:0] sat_val,
    output logic [STARVE_W-1:0] cnt,
    output logic                at_max
);

    logic [STARVE_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= STARVE_ZERO;
        end else if (clr) begin
            r_cnt <= STARVE_ZERO;
        end else if (inc && (r_cnt < sat_val)) begin
            r_cnt <= r_cnt + STARVE_W'(1);
        end
    end

    assign cnt    = r_cnt;
    assign at_max = (r_cnt == sat_val);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch reads and data reads/writes.
// Data wins by default; a starvation counter forces fetch through periodically.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | no transaction; arbitrate pending requests
//   BUSY_I  | fetch read issued, waiting for mem_ack
//   BUSY_D  | data read/write issued, waiting for mem_ack
//   RESP_I  | i_ack pulse, i_rdata valid
//   RESP_D  | d_ack pulse, d_rdata valid (reads)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_i,
    output logic              stall_d,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_fetch_due;
    logic                w_at_max;
    logic [STARVE_W-1:0] w_starve_cnt;
    logic                w_starve_inc;
    logic                w_starve_clr;

    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    // A zero threshold would lock data out entirely, so it never forces fetch.
    assign w_fetch_due = w_at_max && (w_starve_cnt != STARVE_ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (d_req && !(i_req && w_fetch_due)) begin
                    w_grant_d    = 1'b1;
                    w_state_next = ST_BUSY_D;
                end else if (i_req) begin
                    w_grant_i    = 1'b1;
                    w_state_next = ST_BUSY_I;
                end
            end
            ST_BUSY_I: if (mem_ack) w_state_next = ST_RESP_I;
            ST_BUSY_D: if (mem_ack) w_state_next = ST_RESP_D;
            ST_RESP_I: w_state_next = ST_IDLE;
            ST_RESP_D: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    assign w_starve_inc = w_grant_d && i_req;
    assign w_starve_clr = w_grant_i || (w_grant_d && !i_req);

    arb_starve_counter u_starve (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_starve_clr),
        .inc     (w_starve_inc),
        .sat_val (STARVE_W'(STARVE_MAX)),
        .cnt     (w_starve_cnt),
        .at_max  (w_at_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            if (w_grant_d) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= d_we;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
            end else if (w_grant_i) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= i_addr;
                r_mem_wdata <= '0;
            end
            // Stray acks outside BUSY never reach here.
            if (mem_ack && (r_state == ST_BUSY_I)) begin
                r_mem_req <= 1'b0;
                r_i_rdata <= mem_rdata;
            end
            if (mem_ack && (r_state == ST_BUSY_D)) begin
                r_mem_req <= 1'b0;
                if (!r_mem_we) r_d_rdata <= mem_rdata;
            end
        end
    end

    assign i_ack     = (r_state == ST_RESP_I);
    assign d_ack     = (r_state == ST_RESP_D);
    assign stall_i   = i_req && !i_ack;
    assign stall_d   = d_req && !d_ack;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
